// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, requester limit and arbiter states.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_MAX_REQUESTERS = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE      = ST_IDLE,
    ARB_ISSUE     = ST_ISSUE,
    ARB_WAIT_DONE = ST_WAIT
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after last_owner.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_owner,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_idx
);

  logic found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last_owner) + k) % N;
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-holding round-robin arbiter in front of a byte-wide UART TX core.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int REQUESTERS = 4,
  parameter int MAX_BURST  = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [REQUESTERS-1:0]            req,
  input  logic [8*REQUESTERS-1:0]          req_byte,
  input  logic [REQUESTERS-1:0]            req_last,
  output logic [REQUESTERS-1:0]            req_ack,
  output logic [REQUESTERS-1:0]            grant,
  output logic                             tx_start,
  output logic [UART_DATA_BITS-1:0]        tx_byte,
  input  logic                             tx_busy,
  input  logic                             tx_done
);

  localparam int IW = $clog2(REQUESTERS);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  arb_state_t state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last_owner;
  logic [7:0] burst_cnt;
  logic last_flag;

  logic [REQUESTERS-1:0] pick;
  logic [IW-1:0] pick_idx;
  logic own_req;
  logic fire;
  logic wrap_up;

  rr_pick #(
    .N (REQUESTERS),
    .IW(IW)
  ) u_pick (
    .req       (req),
    .last_owner(last_owner),
    .pick      (pick),
    .pick_idx  (pick_idx)
  );

  assign own_req = req[owner];
  assign fire = (state == ARB_ISSUE) && own_req && !tx_busy;
  assign wrap_up = last_flag || (burst_cnt == BURST_MAX) || !own_req;

  assign tx_start = fire;
  assign tx_byte  = fire ? req_byte[8*owner +: 8] : '0;
  assign req_ack  = fire ? ({{(REQUESTERS-1){1'b0}}, 1'b1} << owner) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= IW'(REQUESTERS - 1);
      burst_cnt  <= '0;
      last_flag  <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (|req) begin
            owner     <= pick_idx;
            grant     <= pick;
            burst_cnt <= '0;
            state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (!own_req) begin
            last_owner <= owner;
            grant      <= '0;
            state      <= ARB_IDLE;
          end else if (!tx_busy) begin
            last_flag <= req_last[owner];
            if (burst_cnt != BURST_MAX)
              burst_cnt <= burst_cnt + 8'd1;
            state <= ARB_WAIT_DONE;
          end
        end
        ARB_WAIT_DONE: begin
          // The owner's decision on tx_done precedes any new arbitration.
          if (tx_done) begin
            if (wrap_up) begin
              last_owner <= owner;
              grant      <= '0;
              state      <= ARB_IDLE;
            end else begin
              state <= ARB_ISSUE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: source queues and a TX core model around two arbiters.
module tb_uart_tx_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst[2];
  logic [3:0]  req[2];
  logic [31:0] req_byte[2];
  logic [3:0]  req_last[2];
  logic [3:0]  req_ack[2];
  logic [3:0]  grant[2];
  logic        tx_start[2];
  logic [7:0]  tx_byte[2];
  logic        tx_busy[2];
  logic        tx_done[2];
  logic        ext_busy[2];
  logic [3:0]  drop[2];
  int          frame_len[2];

  // h0: default burst limit, h1: burst limit of 2
  uart_tx_arbiter #(.REQUESTERS(4), .MAX_BURST(16)) dut0 (
    .clock(clock), .reset(rst[0]), .req(req[0]), .req_byte(req_byte[0]),
    .req_last(req_last[0]), .req_ack(req_ack[0]), .grant(grant[0]),
    .tx_start(tx_start[0]), .tx_byte(tx_byte[0]), .tx_busy(tx_busy[0]),
    .tx_done(tx_done[0])
  );

  uart_tx_arbiter #(.REQUESTERS(4), .MAX_BURST(2)) dut1 (
    .clock(clock), .reset(rst[1]), .req(req[1]), .req_byte(req_byte[1]),
    .req_last(req_last[1]), .req_ack(req_ack[1]), .grant(grant[1]),
    .tx_start(tx_start[1]), .tx_byte(tx_byte[1]), .tx_busy(tx_busy[1]),
    .tx_done(tx_done[1])
  );

  logic [7:0] mem_b[2][4][32];
  logic       mem_l[2][4][32];
  int         head[2][4];
  int         tail[2][4];
  int         tx_cnt[2];

  always @(posedge clock)
    for (int hh = 0; hh < 2; hh++)
      for (int i = 0; i < 4; i++)
        if (req_ack[hh][i]) head[hh][i] <= head[hh][i] + 1;

  always_comb begin
    for (int hh = 0; hh < 2; hh++) begin
      req[hh] = '0;
      req_last[hh] = '0;
      req_byte[hh] = '0;
      for (int i = 0; i < 4; i++) begin
        req[hh][i] = (head[hh][i] < tail[hh][i]) && !drop[hh][i];
        req_byte[hh][8*i +: 8] = mem_b[hh][i][5'(head[hh][i])];
        req_last[hh][i] = mem_l[hh][i][5'(head[hh][i])];
      end
    end
  end

  // TX core model: busy for frame_len cycles, then one done pulse
  always @(posedge clock)
    for (int hh = 0; hh < 2; hh++) begin
      tx_done[hh] <= 1'b0;
      if (tx_start[hh]) tx_cnt[hh] <= frame_len[hh];
      else if (tx_cnt[hh] > 1) tx_cnt[hh] <= tx_cnt[hh] - 1;
      else if (tx_cnt[hh] == 1) begin
        tx_cnt[hh] <= 0;
        tx_done[hh] <= 1'b1;
      end
    end

  always_comb
    for (int hh = 0; hh < 2; hh++)
      tx_busy[hh] = (tx_cnt[hh] != 0) || ext_busy[hh];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int         last_done[2];
  int         ev_n[2];
  int         ev_src[2][64];
  int         ev_acks[2][64];
  int         ev_gap[2][64];
  logic [7:0] ev_byte[2][64];

  always @(negedge clock)
    for (int hh = 0; hh < 2; hh++) begin
      if (tx_done[hh] === 1'b1) last_done[hh] = cyc;
      if (tx_start[hh] && !rst[hh] && ev_n[hh] < 64) begin
        int s;
        s = -1;
        for (int k = 0; k < 4; k++) if (req_ack[hh][k]) s = k;
        ev_src[hh][ev_n[hh]] = s;
        ev_acks[hh][ev_n[hh]] = $countones(req_ack[hh]);
        ev_byte[hh][ev_n[hh]] = tx_byte[hh];
        ev_gap[hh][ev_n[hh]] = cyc - last_done[hh];
        ev_n[hh] = ev_n[hh] + 1;
      end
    end

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(int hh, int i, logic [7:0] b, logic l);
    mem_b[hh][i][5'(tail[hh][i])] = b;
    mem_l[hh][i][5'(tail[hh][i])] = l;
    tail[hh][i] = tail[hh][i] + 1;
  endtask

  function automatic bit is_idle(int hh);
    bit idle;
    idle = (tx_cnt[hh] == 0) && (grant[hh] == 4'd0) && !tx_start[hh];
    for (int i = 0; i < 4; i++)
      if (head[hh][i] < tail[hh][i] && !drop[hh][i]) idle = 0;
    return idle;
  endfunction

  task automatic drain(int hh, string tag, int budget);
    int n;
    n = 0;
    @(posedge clock);
    #1;
    while (n < budget && !is_idle(hh)) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic chk_events(int hh, string tag, int b, int cnt,
                            int srcs[6], logic [7:0] bytes[6]);
    chk($sformatf("%s_count", tag), ev_n[hh] - b, cnt);
    for (int k = 0; k < cnt; k++) begin
      chk($sformatf("%s_src%0d", tag, k), ev_src[hh][b+k], srcs[k]);
      chk($sformatf("%s_byte%0d", tag, k), ev_byte[hh][b+k], bytes[k]);
      chk($sformatf("%s_acks%0d", tag, k), ev_acks[hh][b+k], 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b, n, st, stray, dones;
    int srcs[6];
    logic [7:0] bytes[6];
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    ext_busy[0] = 1'b0;
    ext_busy[1] = 1'b0;
    drop[0] = '0;
    drop[1] = '0;
    frame_len[0] = 10;
    frame_len[1] = 10;
    repeat (3) @(posedge clock);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clock);
    chk("rst_grant", grant[0], 0);
    chk("rst_start", tx_start[0], 0);
    chk("rst_ack", req_ack[0], 0);
    chk("rst_byte", tx_byte[0], 0);
    chk("rst_grant_b", grant[1], 0);

    // single source, long frame
    frame_len[0] = 100;
    @(posedge clock);
    #1;
    b = ev_n[0];
    push(0, 0, 8'h41, 1'b1);
    @(posedge clock);
    @(negedge clock);
    chk("t1_grant", grant[0], 4'b0001);
    chk("t1_start", tx_start[0], 1);
    chk("t1_byte", tx_byte[0], 8'h41);
    chk("t1_ack", req_ack[0], 4'b0001);
    drain(0, "t1_drain", 300);
    chk("t1_idle_grant", grant[0], 0);
    chk("t1_count", ev_n[0] - b, 1);
    frame_len[0] = 10;

    // packet hold while src2 waits
    b = ev_n[0];
    push(0, 1, 8'h10, 1'b0);
    push(0, 1, 8'h11, 1'b0);
    push(0, 1, 8'h12, 1'b1);
    push(0, 2, 8'h20, 1'b1);
    drain(0, "t2_drain", 400);
    srcs = '{1, 1, 1, 2, 0, 0};
    bytes = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h00, 8'h00};
    chk_events(0, "t2", b, 4, srcs, bytes);
    chk("t2_gap1", ev_gap[0][b+1], 1);
    chk("t2_gap2", ev_gap[0][b+2], 1);

    // fairness from a fresh reset
    @(posedge clock);
    #1;
    rst[0] = 1'b1;
    @(posedge clock);
    #1;
    rst[0] = 1'b0;
    b = ev_n[0];
    push(0, 0, 8'hA0, 1'b1);
    push(0, 1, 8'hA1, 1'b1);
    push(0, 2, 8'hA2, 1'b1);
    push(0, 3, 8'hA3, 1'b1);
    push(0, 0, 8'hA4, 1'b1);
    drain(0, "t3_drain", 400);
    srcs = '{0, 1, 2, 3, 0, 0};
    bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00};
    chk_events(0, "t3", b, 5, srcs, bytes);

    // burst limit 2 on the second instance
    b = ev_n[1];
    push(1, 0, 8'hB0, 1'b0);
    push(1, 0, 8'hB1, 1'b0);
    push(1, 0, 8'hB2, 1'b0);
    push(1, 0, 8'hB3, 1'b0);
    push(1, 0, 8'hB4, 1'b1);
    push(1, 3, 8'hC0, 1'b1);
    drain(1, "t4_drain", 500);
    srcs = '{0, 0, 3, 0, 0, 0};
    bytes = '{8'hB0, 8'hB1, 8'hC0, 8'hB2, 8'hB3, 8'hB4};
    chk_events(1, "t4", b, 6, srcs, bytes);
    chk("t4_gap1", ev_gap[1][b+1], 1);

    // busy stall
    b = ev_n[0];
    ext_busy[0] = 1'b1;
    push(0, 1, 8'h55, 1'b1);
    st = 0;
    repeat (21) begin
      @(negedge clock);
      if (tx_start[0]) st++;
    end
    chk("t5_stall", st, 0);
    chk("t5_grant", grant[0], 4'b0010);
    @(posedge clock);
    #1;
    ext_busy[0] = 1'b0;
    @(negedge clock);
    chk("t5_start", tx_start[0], 1);
    chk("t5_byte", tx_byte[0], 8'h55);
    chk("t5_ack", req_ack[0], 4'b0010);
    drain(0, "t5_drain", 200);

    // src2 drops its request after grant
    b = ev_n[0];
    ext_busy[0] = 1'b1;
    push(0, 2, 8'h66, 1'b1);
    @(posedge clock);
    #1;
    chk("t5d_grant", grant[0], 4'b0100);
    drop[0][2] = 1'b1;
    ext_busy[0] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("t5d_release", grant[0], 0);
    chk("t5d_nostart", ev_n[0] - b, 0);
    @(posedge clock);
    #1;
    push(0, 0, 8'h70, 1'b1);
    push(0, 3, 8'h73, 1'b1);
    drain(0, "t5d_drain", 200);
    chk("t5d_next_src", ev_src[0][b], 3);
    chk("t5d_then_src", ev_src[0][b+1], 0);

    // reset during WAIT_DONE, stray done afterwards
    frame_len[0] = 7;
    @(posedge clock);
    #1;
    push(0, 1, 8'h77, 1'b1);
    n = 0;
    @(negedge clock);
    while (!tx_start[0] && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("t6_started", 32'(n < 20), 1);
    repeat (3) @(posedge clock);
    #1;
    rst[0] = 1'b1;
    @(posedge clock);
    #1;
    rst[0] = 1'b0;
    @(negedge clock);
    chk("t6_grant", grant[0], 0);
    chk("t6_start", tx_start[0], 0);
    chk("t6_ack", req_ack[0], 0);
    chk("t6_byte", tx_byte[0], 0);
    stray = 0;
    dones = 0;
    repeat (12) begin
      @(negedge clock);
      if (tx_done[0]) dones++;
      if (tx_start[0] || req_ack[0] != 0 || grant[0] != 0) stray++;
    end
    chk("t6_done_seen", dones, 1);
    chk("t6_stray", stray, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
